dsp_branch: RTL

Branch and flow-control unit for the DSP core: sits between the Decode stage and the Fetch stage, evaluates decoded branch-class instructions and hardware-loop ends, and drives the redirect pair (jump_addr, jump_flag) consumed by Fetch. It holds an 8-deep return-address stack for CALL/RET and a single-level zero-overhead loop controller. All outputs are registered, so the redirect appears one cycle after the deciding instruction is presented.

---
 rtl/dsp_branch.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dsp_branch.sv
// Branch and flow-control unit between Decode and Fetch: evaluates branch-class ops,
// keeps a return-address stack and a single-level zero-overhead loop, registered redirect.
module dsp_branch #(
  parameter int ADDR_W      = 16,
  parameter int CNT_W       = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] target,
  input  logic [CNT_W-1:0]  loop_count,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              jump_flag,
  output logic              loop_active,
  output logic              stack_err
);

  // Handshake: valid_in qualifies op/pc_in/target/loop_count/zero_flag for one cycle;
  // there is no back-pressure, and jump_flag is a one-cycle strobe Fetch must take.

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
  localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
  localparam logic [PTR_W:0]    PTR_ONE   = 1;
  localparam logic [PTR_W:0]    PTR_FULL  = (PTR_W+1)'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_JMP  = 3'b001,
    OP_JZ   = 3'b010,
    OP_JNZ  = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101,
    OP_LOOP = 3'b110,
    OP_RSV  = 3'b111
  } op_e;

  op_e op_v;
  assign op_v = op_e'(op);

  logic [ADDR_W-1:0] jump_addr_q, jump_addr_d;
  logic              jump_flag_q, jump_flag_d;
  logic              loop_active_q, loop_active_d;
  logic              stack_err_q, stack_err_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              push_en;
  logic [ADDR_W-1:0] ret_addr;
  logic [PTR_W:0]    cnt_dec;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  top_idx;

  assign ret_addr = pc_in + ADDR_ONE;
  assign cnt_dec  = cnt_q - PTR_ONE;
  assign wr_idx   = cnt_q[PTR_W-1:0];
  assign top_idx  = cnt_dec[PTR_W-1:0];

  always_comb begin
    jump_flag_d   = 1'b0;
    jump_addr_d   = jump_addr_q;
    loop_active_d = loop_active_q;
    stack_err_d   = stack_err_q;
    cnt_d         = cnt_q;
    remaining_d   = remaining_q;
    start_d       = start_q;
    end_d         = end_q;
    push_en       = 1'b0;

    if (valid_in) begin
      case (op_v)
        OP_JMP: begin
          jump_flag_d = 1'b1;
          jump_addr_d = target;
        end
        OP_JZ: begin
          if (zero_flag) begin
            jump_flag_d = 1'b1;
            jump_addr_d = target;
          end
        end
        OP_JNZ: begin
          if (!zero_flag) begin
            jump_flag_d = 1'b1;
            jump_addr_d = target;
          end
        end
        OP_CALL: begin
          if (cnt_q != PTR_FULL) begin
            push_en     = 1'b1;
            cnt_d       = cnt_q + PTR_ONE;
            jump_flag_d = 1'b1;
            jump_addr_d = target;
          end else begin
            stack_err_d = 1'b1;
          end
        end
        OP_RET: begin
          if (cnt_q != '0) begin
            cnt_d       = cnt_dec;
            jump_flag_d = 1'b1;
            jump_addr_d = stack_q[top_idx];
          end else begin
            stack_err_d = 1'b1;
          end
        end
        OP_LOOP: begin
          if (loop_active_q) begin
            stack_err_d = 1'b1;
          end else if (loop_count == CNT_ZERO) begin
            jump_flag_d = 1'b1;
            jump_addr_d = target + ADDR_ONE;
          end else begin
            loop_active_d = 1'b1;
            start_d       = ret_addr;
            end_d         = target;
            remaining_d   = loop_count;
          end
        end
        default: ;
      endcase

      // An explicit taken branch at the loop end overrides the loop-back.
      if (loop_active_q && (pc_in == end_q) && !jump_flag_d) begin
        if (remaining_q > CNT_ONE) begin
          remaining_d = remaining_q - CNT_ONE;
          jump_flag_d = 1'b1;
          jump_addr_d = start_q;
        end else begin
          remaining_d   = CNT_ZERO;
          loop_active_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      jump_addr_q   <= '0;
      jump_flag_q   <= 1'b0;
      loop_active_q <= 1'b0;
      stack_err_q   <= 1'b0;
      cnt_q         <= '0;
      remaining_q   <= '0;
      start_q       <= '0;
      end_q         <= '0;
    end else begin
      jump_addr_q   <= jump_addr_d;
      jump_flag_q   <= jump_flag_d;
      loop_active_q <= loop_active_d;
      stack_err_q   <= stack_err_d;
      cnt_q         <= cnt_d;
      remaining_q   <= remaining_d;
      start_q       <= start_d;
      end_q         <= end_d;
    end
  end

  // Stack storage needs no reset: entries are only read below the live count.
  always_ff @(posedge clk) begin
    if (!rst && push_en) begin
      stack_q[wr_idx] <= ret_addr;
    end
  end

  assign jump_addr   = jump_addr_q;
  assign jump_flag   = jump_flag_q;
  assign loop_active = loop_active_q;
  assign stack_err   = stack_err_q;

endmodule
